// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader.
// Imported by the loader top and its address counter.
package boot_loader_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 7;
    localparam int MEM_DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_I = 2'd1,
        LOAD_D = 2'd2,
        RUN    = 2'd3
    } state_e;

endpackage

// File: rtl/loader_addr_cnt.sv
// Write-address counter for the boot loader.
// Clear has priority over increment; last_o flags the final word.
module loader_addr_cnt
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W:0]   len_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_q;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Count accepted words, restarting whenever a phase begins or ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (({1'b0, cnt_q} + ONE) == len_i);

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams host words into instruction then data memory,
// then releases the processor until halted.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   inst_len,
    input  logic [ADDR_W:0]   data_len,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              halt,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] instructionAddress,
    output logic              inst_we,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] dataAddress,
    output logic              writeEnable,
    output logic              cpu_run,
    output logic              busy,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q;
    logic [ADDR_W:0]   ilen_q;
    logic [ADDR_W:0]   dlen_q;
    logic              err_q;
    logic              iwe_q;
    logic [DATA_W-1:0] iword_q;
    logic [ADDR_W-1:0] iaddr_q;
    logic              dwe_q;
    logic [DATA_W-1:0] dword_q;
    logic [ADDR_W-1:0] daddr_q;

    logic              beat;
    logic              len_bad;
    logic [ADDR_W:0]   len_sel;
    logic              cnt_clr;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_last;

    // Handshake and counter control derived from the current state.
    always_comb begin
        host_ready = (state_q == LOAD_I) || (state_q == LOAD_D);
        busy       = host_ready;
        cpu_run    = (state_q == RUN);
        beat       = host_valid && host_ready;
        len_bad    = (inst_len > DEPTH) || (data_len > DEPTH);
        len_sel    = (state_q == LOAD_D) ? dlen_q : ilen_q;
        cnt_clr    = halt || !host_ready || (beat && cnt_last);
    end

    loader_addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (beat),
        .len_i  (len_sel),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Loader FSM with registered write ports; halt overrides any transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ilen_q  <= '0;
            dlen_q  <= '0;
            err_q   <= 1'b0;
            iwe_q   <= 1'b0;
            iword_q <= '0;
            iaddr_q <= '0;
            dwe_q   <= 1'b0;
            dword_q <= '0;
            daddr_q <= '0;
        end else begin
            iwe_q <= 1'b0;
            dwe_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!halt && start) begin
                        if (len_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b0;
                            ilen_q <= inst_len;
                            dlen_q <= data_len;
                            if (inst_len != '0) begin
                                state_q <= LOAD_I;
                            end else if (data_len != '0) begin
                                state_q <= LOAD_D;
                            end else begin
                                state_q <= RUN;
                            end
                        end
                    end
                end
                LOAD_I: begin
                    if (beat) begin
                        iwe_q   <= 1'b1;
                        iword_q <= host_data;
                        iaddr_q <= cnt;
                        if (cnt_last) begin
                            state_q <= (dlen_q != '0) ? LOAD_D : RUN;
                        end
                    end
                    if (halt) begin
                        state_q <= IDLE;
                    end
                end
                LOAD_D: begin
                    if (beat) begin
                        dwe_q   <= 1'b1;
                        dword_q <= host_data;
                        daddr_q <= cnt;
                        if (cnt_last) begin
                            state_q <= RUN;
                        end
                    end
                    if (halt) begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instruction        = iword_q;
    assign instructionAddress = iaddr_q;
    assign inst_we            = iwe_q;
    assign data               = dword_q;
    assign dataAddress        = daddr_q;
    assign writeEnable        = dwe_q;
    assign error              = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader.
// Expected memory writes are queued at stimulus time and popped on strobes.
module tb_boot_loader;
    import boot_loader_pkg::*;

    localparam int DW = 32;
    localparam int AW = 7;

    typedef struct {
        bit              is_d;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   word;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   inst_len;
    logic [AW:0]   data_len;
    logic          host_valid;
    logic [DW-1:0] host_data;
    logic          host_ready;
    logic          halt;
    logic [DW-1:0] instruction;
    logic [AW-1:0] instructionAddress;
    logic          inst_we;
    logic [DW-1:0] data;
    logic [AW-1:0] dataAddress;
    logic          writeEnable;
    logic          cpu_run;
    logic          busy;
    logic          error;

    wr_t           exp_q[$];
    int            n_chk;
    int            n_err;
    int            n_istb;
    logic [AW-1:0] last_iaddr;

    boot_loader #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .inst_len           (inst_len),
        .data_len           (data_len),
        .host_valid         (host_valid),
        .host_data          (host_data),
        .host_ready         (host_ready),
        .halt               (halt),
        .instruction        (instruction),
        .instructionAddress (instructionAddress),
        .inst_we            (inst_we),
        .data               (data),
        .dataAddress        (dataAddress),
        .writeEnable        (writeEnable),
        .cpu_run            (cpu_run),
        .busy               (busy),
        .error              (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_d, input int a, input logic [DW-1:0] w);
        wr_t e;
        e.is_d = is_d;
        e.addr = AW'(a);
        e.word = w;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic go_idle();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    // Scoreboard: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (rst_n) begin
            check("excl", 64'(inst_we & writeEnable), 64'd0);
            if (inst_we || writeEnable) begin
                if (exp_q.size() == 0) begin
                    check("unexp_wr", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("kind", 64'(writeEnable), 64'(e.is_d));
                    if (e.is_d) begin
                        check("daddr", 64'(dataAddress), 64'(e.addr));
                        check("dword", 64'(data), 64'(e.word));
                    end else begin
                        check("iaddr", 64'(instructionAddress), 64'(e.addr));
                        check("iword", 64'(instruction), 64'(e.word));
                    end
                end
            end
            if (inst_we) begin
                n_istb++;
                last_iaddr = instructionAddress;
            end
        end
    end

    initial begin
        logic [DW-1:0] w1[5];
        w1 = '{32'h20220003, 32'h11, 32'h22, 32'd12, 32'd13};
        n_chk = 0;
        n_err = 0;
        n_istb = 0;
        last_iaddr = '0;
        rst_n = 1'b0;
        start = 1'b0;
        inst_len = '0;
        data_len = '0;
        host_valid = 1'b0;
        host_data = '0;
        halt = 1'b0;
        tick();
        tick();
        check("rst_ready", 64'(host_ready), 64'd0);
        check("rst_run", 64'(cpu_run), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(error), 64'd0);
        check("rst_iwe", 64'(inst_we), 64'd0);
        check("rst_dwe", 64'(writeEnable), 64'd0);
        check("rst_iaddr", 64'(instructionAddress), 64'd0);
        check("rst_daddr", 64'(dataAddress), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic 3 instruction + 2 data word load.
        start = 1'b1;
        inst_len = 8'd3;
        data_len = 8'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) push(i >= 3, (i >= 3) ? i - 3 : i, w1[i]);
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1;
            host_data = w1[i];
            @(negedge clk);
            check("ld_ready", 64'(host_ready), 64'd1);
            check("ld_busy", 64'(busy), 64'd1);
            tick();
        end
        host_valid = 1'b0;
        tick();
        check("run1", 64'(cpu_run), 64'd1);
        check("run1_busy", 64'(busy), 64'd0);
        drain();

        // Empty image goes straight to RUN.
        go_idle();
        check("idle_run", 64'(cpu_run), 64'd0);
        start = 1'b1;
        inst_len = 8'd0;
        data_len = 8'd0;
        tick();
        start = 1'b0;
        check("empty_run", 64'(cpu_run), 64'd1);
        check("empty_ready", 64'(host_ready), 64'd0);
        host_valid = 1'b1;
        tick();
        check("empty_ready2", 64'(host_ready), 64'd0);
        host_valid = 1'b0;

        // Oversized length is rejected, then a good start clears error.
        go_idle();
        start = 1'b1;
        inst_len = 8'd129;
        data_len = 8'd0;
        tick();
        start = 1'b0;
        check("bad_err", 64'(error), 64'd1);
        check("bad_ready", 64'(host_ready), 64'd0);
        check("bad_busy", 64'(busy), 64'd0);
        check("bad_run", 64'(cpu_run), 64'd0);
        start = 1'b1;
        inst_len = 8'd1;
        tick();
        start = 1'b0;
        check("good_err", 64'(error), 64'd0);
        check("good_busy", 64'(busy), 64'd1);
        push(1'b0, 0, 32'hcafe0001);
        host_valid = 1'b1;
        host_data = 32'hcafe0001;
        tick();
        host_valid = 1'b0;
        tick();
        check("one_run", 64'(cpu_run), 64'd1);
        drain();

        // Full-depth load with a gapped host stream.
        go_idle();
        start = 1'b1;
        inst_len = 8'(MEM_DEPTH);
        data_len = 8'd0;
        tick();
        start = 1'b0;
        n_istb = 0;
        for (int i = 0; i < 256; i++) begin
            host_valid = (i % 2 == 0);
            host_data = $urandom;
            if (host_valid) push(1'b0, i / 2, host_data);
            tick();
        end
        host_valid = 1'b0;
        drain();
        check("full_cnt", 64'(n_istb), 64'd128);
        check("full_last", 64'(last_iaddr), 64'd127);
        check("full_run", 64'(cpu_run), 64'd1);

        // Reset in the middle of a load.
        go_idle();
        start = 1'b1;
        inst_len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            host_valid = 1'b1;
            host_data = 32'h5a00 + i;
            push(1'b0, i, host_data);
            tick();
        end
        host_valid = 1'b0;
        tick();
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_ready", 64'(host_ready), 64'd0);
        check("ar_iaddr", 64'(instructionAddress), 64'd0);
        check("ar_iword", 64'(instruction), 64'd0);
        tick();
        rst_n = 1'b1;
        host_valid = 1'b1;
        host_data = 32'hdead;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_ready", 64'(host_ready), 64'd0);
            tick();
        end
        host_valid = 1'b0;

        // halt beats start in RUN and in IDLE.
        start = 1'b1;
        inst_len = 8'd0;
        data_len = 8'd0;
        tick();
        check("h_run", 64'(cpu_run), 64'd1);
        halt = 1'b1;
        inst_len = 8'd1;
        tick();
        check("h_stop", 64'(cpu_run), 64'd0);
        check("h_busy", 64'(busy), 64'd0);
        tick();
        check("h_idle_run", 64'(cpu_run), 64'd0);
        check("h_idle_busy", 64'(busy), 64'd0);
        check("h_idle_ready", 64'(host_ready), 64'd0);
        halt = 1'b0;
        start = 1'b0;
        tick();
        check("h_final", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
